alu_share_ctrl: RTL and testbench

Sequencing controller that shares one combinational ALU between two requesters, for example the integer pipeline (port 0) and the address/branch unit (port 1). Each requester hands over operands, opcode and tag with valid/ready. The block arbitrates, registers the operands into the ALU, and captures result and flags. It returns a response with the requester's tag on that requester's response channel and holds it until accepted.

---
 rtl/alu_pkg.sv | 45 ++++
 rtl/alu_arb2.sv | 27 ++
 rtl/alu_share_ctrl.sv | 134 +++++++++++++
 tb/tb_alu_share_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the two-requester ALU sharing controller.
package alu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned FLG_W  = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
  localparam logic [OP_W-1:0] OP_SLL  = 4'b0001;
  localparam logic [OP_W-1:0] OP_SLT  = 4'b0010;
  localparam logic [OP_W-1:0] OP_SLTU = 4'b0011;
  localparam logic [OP_W-1:0] OP_XOR  = 4'b0100;
  localparam logic [OP_W-1:0] OP_SRL  = 4'b0101;
  localparam logic [OP_W-1:0] OP_OR   = 4'b0110;
  localparam logic [OP_W-1:0] OP_AND  = 4'b0111;
  localparam logic [OP_W-1:0] OP_SUB  = 4'b1000;
  localparam logic [OP_W-1:0] OP_SRA  = 4'b1101;

  // Bit positions inside rsp_flags = {ZF,CF,OF,SF}
  localparam int unsigned FLG_Z = 3;
  localparam int unsigned FLG_C = 2;
  localparam int unsigned FLG_O = 1;
  localparam int unsigned FLG_S = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
  } alu_req_t;

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
      OP_SRL, OP_OR, OP_AND, OP_SUB, OP_SRA: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_arb2.sv
// Two-way one-hot arbiter. ALU_ARB_RR_EN selects round-robin on ties;
// otherwise port 0 has fixed priority.
module alu_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant_c
);

`ifdef ALU_ARB_RR_EN
  // On a tie, the port that did not win last time goes first
  always_comb begin
    grant_c = 2'b00;
    if (&req) grant_c = last_grant ? 2'b01 : 2'b10;
    else      grant_c = req;
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  always_comb begin
    grant_c = 2'b00;
    if (req[0])      grant_c = 2'b01;
    else if (req[1]) grant_c = 2'b10;
  end
`endif

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external combinational ALU between two valid/ready requesters.
// Arbitration policy is set by the ALU_ARB_RR_EN macro (see alu_arb2).
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_b0,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b1,
  input  logic [OP_W-1:0]   req_op0,
  input  logic [OP_W-1:0]   req_op1,
  input  logic [TAG_W-1:0]  req_tag0,
  input  logic [TAG_W-1:0]  req_tag1,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_out,
  output logic [FLG_W-1:0]  rsp_flags,
  output logic              rsp_err,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_cf,
  input  logic              alu_of
);

  state_t             state_q, state_d;
  logic [1:0]         grant_c;
  logic               win_c;
  logic               last_grant_q;
  logic               owner_q;
  logic [TAG_W-1:0]   tag_q;
  logic               accept_c, capture_c, release_c;
  alu_req_t           win_req_c;
  logic [TAG_W-1:0]   win_tag_c;
  logic               legal_c;
  logic [DATA_W-1:0]  res_c;
  logic [FLG_W-1:0]   flags_c;

  alu_arb2 u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant_c    (grant_c)
  );

  // Ready only in IDLE and only toward the arbitration winner
  assign req_ready = (state_q == ST_IDLE) ? grant_c : 2'b00;
  assign win_c     = grant_c[1];
  assign win_req_c = win_c ? {req_a1, req_b1, req_op1} : {req_a0, req_b0, req_op0};
  assign win_tag_c = win_c ? req_tag1 : req_tag0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    accept_c  = 1'b0;
    capture_c = 1'b0;
    release_c = 1'b0;
    case (state_q)
      ST_IDLE: if (|req_ready) begin
        accept_c = 1'b1;
        state_d  = ST_EXEC;
      end
      ST_EXEC: begin
        capture_c = 1'b1;
        state_d   = ST_RESP;
      end
      ST_RESP: if (rsp_ready[owner_q]) begin
        release_c = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Result and flags; illegal opcodes report zero result/flags with err set
  always_comb begin
    legal_c = is_legal_op(alu_op);
    res_c   = legal_c ? alu_out : '0;
    flags_c = '0;
    if (legal_c) begin
      flags_c[FLG_Z] = (res_c == '0);
      flags_c[FLG_S] = res_c[DATA_W-1];
      if (alu_op == OP_ADD || alu_op == OP_SUB) begin
        flags_c[FLG_C] = alu_cf;
        flags_c[FLG_O] = alu_of;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op       <= '0;
      tag_q        <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_valid    <= 2'b00;
      rsp_out      <= '0;
      rsp_flags    <= '0;
      rsp_err      <= 1'b0;
      rsp_tag      <= '0;
    end else begin
      if (accept_c) begin
        alu_a        <= win_req_c.a;
        alu_b        <= win_req_c.b;
        alu_op       <= win_req_c.op;
        tag_q        <= win_tag_c;
        owner_q      <= win_c;
        last_grant_q <= win_c;
      end
      if (capture_c) begin
        rsp_out   <= res_c;
        rsp_flags <= flags_c;
        rsp_err   <= ~legal_c;
        rsp_tag   <= tag_q;
        rsp_valid <= owner_q ? 2'b10 : 2'b01;
      end
      if (release_c) rsp_valid <= 2'b00;
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl with a behavioural ALU beside the DUT.
module tb_alu_share_ctrl;

  typedef struct packed {
    logic [1:0]  valid;
    logic [31:0] out;
    logic [3:0]  flags;
    logic        err;
    logic [3:0]  tag;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [31:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
  logic [3:0]  req_op0 = '0, req_op1 = '0;
  logic [3:0]  req_tag0 = '0, req_tag1 = '0;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = 2'b00;
  logic [31:0] rsp_out;
  logic [3:0]  rsp_flags;
  logic        rsp_err;
  logic [3:0]  rsp_tag;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_out;
  logic        alu_cf, alu_of;

  int   checks = 0;
  int   failures = 0;
  rsp_t sb[$];

  always #5 clk = ~clk;

  alu_share_ctrl #(.TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_op0(req_op0), .req_op1(req_op1), .req_tag0(req_tag0), .req_tag1(req_tag1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_out(rsp_out),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err), .rsp_tag(rsp_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_cf(alu_cf), .alu_of(alu_of)
  );

  function automatic logic [31:0] alu_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'h0: return a + b;
      4'h1: return a << b[4:0];
      4'h2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h3: return (a < b) ? 32'd1 : 32'd0;
      4'h4: return a ^ b;
      4'h5: return a >> b[4:0];
      4'h6: return a | b;
      4'h7: return a & b;
      4'h8: return a - b;
      4'hD: return $signed(a) >>> b[4:0];
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // {carry/borrow, signed overflow} for ADD and SUB
  function automatic logic [1:0] alu_co(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    if (op == 4'h0) begin
      s = {1'b0, a} + {1'b0, b};
      return {s[32], (a[31] == b[31]) && (s[31] != a[31])};
    end
    if (op == 4'h8) begin
      s = {1'b0, a} - {1'b0, b};
      return {s[32], (a[31] != b[31]) && (s[31] != a[31])};
    end
    return 2'b00;
  endfunction

  function automatic logic tb_legal(input logic [3:0] op);
    return op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hD};
  endfunction

  function automatic rsp_t make_exp(input logic p, input logic [31:0] a, input logic [31:0] b,
                                    input logic [3:0] op, input logic [3:0] tag);
    rsp_t        e;
    logic [31:0] r;
    logic [1:0]  co;
    e.valid = p ? 2'b10 : 2'b01;
    e.tag   = tag;
    if (!tb_legal(op)) begin
      e.out = '0; e.flags = '0; e.err = 1'b1;
    end else begin
      r  = alu_calc(op, a, b);
      co = alu_co(op, a, b);
      e.out = r; e.flags = {(r == 32'd0), co[1], co[0], r[31]}; e.err = 1'b0;
    end
    return e;
  endfunction

  // Behavioural ALU; drives junk carry/overflow on ops that must ignore them
  always_comb begin
    alu_out = alu_calc(alu_op, alu_a, alu_b);
    if (alu_op == 4'h0 || alu_op == 4'h8) {alu_cf, alu_of} = alu_co(alu_op, alu_a, alu_b);
    else                                  {alu_cf, alu_of} = 2'b11;
  end

  task automatic send(input logic p, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] op, input logic [3:0] tag, output bit ok);
    ok = 1'b0;
    if (p) begin req_a1 = a; req_b1 = b; req_op1 = op; req_tag1 = tag; req_valid[1] = 1'b1; end
    else   begin req_a0 = a; req_b0 = b; req_op0 = op; req_tag0 = tag; req_valid[0] = 1'b1; end
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (p ? req_ready[1] : req_ready[0]) begin
        sb.push_back(make_exp(p, a, b, op, tag));
        ok = 1'b1;
      end
      @(negedge clk);
    end
    if (p) req_valid[1] = 1'b0; else req_valid[0] = 1'b0;
  endtask

  task automatic wait_rsp(output rsp_t got, output int lat, output bit ok);
    ok = 1'b0; lat = 0; got = '0;
    while (!ok && lat < 20) begin
      if (rsp_valid != 2'b00) ok = 1'b1;
      else begin @(negedge clk); lat++; end
    end
    if (ok) begin
      got = {rsp_valid, rsp_out, rsp_flags, rsp_err, rsp_tag};
      rsp_ready = rsp_valid;
      @(negedge clk);
      rsp_ready = 2'b00;
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({req_ready, rsp_valid, rsp_out, rsp_flags, rsp_err, rsp_tag, alu_a, alu_b, alu_op} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got rv=%b rspv=%b out=%h fl=%b err=%b tag=%h a=%h b=%h op=%h exp all zero",
               req_ready, rsp_valid, rsp_out, rsp_flags, rsp_err, rsp_tag, alu_a, alu_b, alu_op);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_add_wrap();
    bit ok; int lat; rsp_t got, exp;
    send(1'b0, 32'hFFFF_FFFF, 32'h1, 4'h0, 4'h3, ok);
    checks++;
    if (!ok || rsp_valid !== 2'b00 || alu_a !== 32'hFFFF_FFFF || alu_op !== 4'h0) begin
      failures++;
      $display("FAIL add_exec got ok=%0d rspv=%b alu_a=%h alu_op=%h exp 1 00 ffffffff 0", ok, rsp_valid, alu_a, alu_op);
    end
    wait_rsp(got, lat, ok);
    checks++;
    if (!ok || lat != 1) begin failures++; $display("FAIL add_latency got ok=%0d lat=%0d exp 1 1", ok, lat); end
    checks++;
    exp = (sb.size() != 0) ? sb.pop_front() : '0;
    if (got !== exp || exp !== {2'b01, 32'h0, 4'b1100, 1'b0, 4'h3}) begin
      failures++; $display("FAIL add_rsp got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_back_to_back();
    int nrsp = 0; int ngr = 0; int cyc = 0;
    logic [3:0] seq = '0; logic [1:0] hs; logic [1:0] upd; rsp_t got, exp;
    rsp_ready = 2'b11;
    req_a0 = 32'h10; req_b0 = 32'h1; req_op0 = 4'h0; req_tag0 = 4'h1;
    req_a1 = 32'h5;  req_b1 = 32'h7; req_op1 = 4'h8; req_tag1 = 4'h2;
    req_valid = 2'b11;
    while (cyc < 60 && nrsp < 4) begin
      #1;
      upd = 2'b00;
      hs = req_valid & req_ready;
      if (rsp_valid != 2'b00) begin
        got = {rsp_valid, rsp_out, rsp_flags, rsp_err, rsp_tag};
        exp = (sb.size() != 0) ? sb.pop_front() : '0;
        checks++;
        if (got !== exp) begin failures++; $display("FAIL b2b_rsp%0d got=%h exp=%h", nrsp, got, exp); end
        nrsp++;
      end
      if (hs != 2'b00 && ngr < 4) begin
        if (hs[1]) sb.push_back(make_exp(1'b1, req_a1, req_b1, req_op1, req_tag1));
        else       sb.push_back(make_exp(1'b0, req_a0, req_b0, req_op0, req_tag0));
        seq = {seq[2:0], hs[1]};
        ngr++;
        upd = hs;
      end
      @(negedge clk);
      cyc++;
      if (upd[0]) begin req_a0 = req_a0 + 32'h7FFF_FFF0; req_tag0 = req_tag0 + 4'h2; end
      if (upd[1]) begin req_b1 = req_b1 ^ 32'h8000_0003; req_tag1 = req_tag1 + 4'h2; end
      if (ngr >= 4) req_valid = 2'b00;
    end
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    checks++;
    if (nrsp != 4 || ngr != 4) begin failures++; $display("FAIL b2b_count got rsp=%0d grants=%0d exp 4 4", nrsp, ngr); end
    checks++;
`ifdef ALU_ARB_RR_EN
    if (seq !== 4'b0101) begin failures++; $display("FAIL b2b_order got=%b exp=0101", seq); end
`else
    if (seq !== 4'b0000) begin failures++; $display("FAIL b2b_order got=%b exp=0000", seq); end
`endif
  endtask

  task automatic test_illegal();
    bit ok; int lat; rsp_t got, exp;
    send(1'b1, 32'h1234_5678, 32'h9, 4'hF, 4'h9, ok);
    wait_rsp(got, lat, ok);
    checks++;
    exp = (sb.size() != 0) ? sb.pop_front() : '0;
    if (!ok || got !== exp || exp !== {2'b10, 32'h0, 4'b0000, 1'b1, 4'h9}) begin
      failures++; $display("FAIL illegal_rsp got=%h exp=%h ok=%0d", got, exp, ok);
    end
  endtask

  task automatic test_hold();
    bit ok; int n; rsp_t got, exp;
    send(1'b0, 32'h8000_0000, 32'h1, 4'h2, 4'h5, ok);
    req_a0 = 32'h3; req_b0 = 32'h4; req_op0 = 4'h0; req_tag0 = 4'h1;
    req_a1 = 32'h6; req_b1 = 32'h2; req_op1 = 4'h8; req_tag1 = 4'h2;
    req_valid = 2'b11;
    n = 0;
    while (rsp_valid == 2'b00 && n < 10) begin @(negedge clk); n++; end
    rsp_ready = 2'b10;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({rsp_valid, rsp_out, req_ready} !== {2'b01, 32'd1, 2'b00}) begin
        failures++; $display("FAIL hold_c%0d got rspv=%b out=%h rdy=%b exp 01 1 00", i, rsp_valid, rsp_out, req_ready);
      end
      @(negedge clk);
    end
    got = {rsp_valid, rsp_out, rsp_flags, rsp_err, rsp_tag};
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
    checks++;
    exp = (sb.size() != 0) ? sb.pop_front() : '0;
    if (!ok || got !== exp) begin failures++; $display("FAIL hold_rsp got=%h exp=%h", got, exp); end
    #1;
    checks++;
`ifdef ALU_ARB_RR_EN
    if (req_ready !== 2'b10) begin failures++; $display("FAIL hold_resume got=%b exp=10", req_ready); end
`else
    if (req_ready !== 2'b01) begin failures++; $display("FAIL hold_resume got=%b exp=01", req_ready); end
`endif
    req_valid = 2'b00;
    @(negedge clk);
    #1;
    checks++;
    if ({req_ready, rsp_valid} !== 4'b0000) begin
      failures++; $display("FAIL drop_req got rdy=%b rspv=%b exp 00 00", req_ready, rsp_valid);
    end
  endtask

  task automatic test_xor();
    bit ok; int lat; rsp_t got, exp;
    send(1'b0, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 4'h4, 4'h7, ok);
    wait_rsp(got, lat, ok);
    checks++;
    exp = (sb.size() != 0) ? sb.pop_front() : '0;
    if (!ok || got !== exp || exp !== {2'b01, 32'h0, 4'b1000, 1'b0, 4'h7}) begin
      failures++; $display("FAIL xor_rsp got=%h exp=%h ok=%0d", got, exp, ok);
    end
  endtask

  task automatic test_ops();
    logic [31:0] ta[8] = '{32'h8000_0000, 32'h1, 32'h8000_0000, 32'h1, 32'h8000_0000, 32'hF0F0, 32'hF000, 32'h7FFF_FFFF};
    logic [31:0] tb[8] = '{32'h4, 32'hFFFF_FFFF, 32'h1, 32'd31, 32'd31, 32'h0F0F, 32'h000F, 32'h1};
    logic [3:0]  to[8] = '{4'hD, 4'h3, 4'h8, 4'h1, 4'h5, 4'h7, 4'h6, 4'h0};
    bit ok; int lat; rsp_t got, exp;
    for (int i = 0; i < 8; i++) begin
      send(1'((i % 2) == 1), ta[i], tb[i], to[i], 4'(i + 8), ok);
      wait_rsp(got, lat, ok);
      checks++;
      exp = (sb.size() != 0) ? sb.pop_front() : '0;
      if (!ok || got !== exp) begin failures++; $display("FAIL ops%0d op=%h got=%h exp=%h", i, to[i], got, exp); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok; int lat; rsp_t got, exp;
    send(1'b1, 32'h1234_5678, 32'h9, 4'h6, 4'h6, ok);
    if (sb.size() != 0) void'(sb.pop_back());
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_out, rsp_flags, rsp_err, rsp_tag, alu_a, alu_b, alu_op} !== '0) begin
      failures++;
      $display("FAIL midreset_outputs got rspv=%b out=%h tag=%h a=%h op=%h exp all zero",
               rsp_valid, rsp_out, rsp_tag, alu_a, alu_op);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 2'b00) begin failures++; $display("FAIL midreset_norsp%0d got=%b exp=00", i, rsp_valid); end
    end
    req_a1 = 32'h2; req_b1 = 32'h3; req_op1 = 4'h0; req_tag1 = 4'hA;
    req_a0 = 32'h4; req_b0 = 32'h5; req_op0 = 4'h0; req_tag0 = 4'hB;
    req_valid = 2'b11;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin failures++; $display("FAIL midreset_tie got=%b exp=01", req_ready); end
    send(1'b0, 32'h4, 32'h5, 4'h0, 4'hB, ok);
    req_valid = 2'b00;
    wait_rsp(got, lat, ok);
    checks++;
    exp = (sb.size() != 0) ? sb.pop_front() : '0;
    if (!ok || got !== exp || exp !== {2'b01, 32'h9, 4'b0000, 1'b0, 4'hB}) begin
      failures++; $display("FAIL midreset_rsp got=%h exp=%h", got, exp);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_add_wrap();
    test_illegal();
    test_hold();
    test_xor();
    test_ops();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
